// File: rtl/instruction_fetch_unit.sv
// Instruction fetch sequencer: reads a 16-bit little-endian instruction at PC
// as two byte reads and pulses the address register file PC increment once per byte.
module instruction_fetch_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] PCIn,
    input  logic [7:0]  MemData,
    input  logic        MemReady,
    output logic [15:0] MemAddr,
    output logic        MemRead,
    output logic [2:0]  ARF_RegSel,
    output logic [1:0]  ARF_FunSel,
    output logic [15:0] IROut,
    output logic        Busy,
    output logic        Done,
    output logic        Error
);

    // A zero TIMEOUT still needs a one-bit counter to keep the declarations legal.
    localparam int unsigned    CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit             TO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ_LO = 3'd1;
    localparam logic [2:0] S_READ_HI = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_ERROR   = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [7:0]       lo_byte;
    logic [7:0]       lo_byte_d;
    logic [15:0]      ir_d;
    logic             capture;
    logic             mem_rd;

    // Next-state, datapath next values and the combinational memory/ARF controls.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        lo_byte_d  = lo_byte;
        ir_d       = IROut;
        capture    = 1'b0;
        mem_rd     = 1'b0;
        MemAddr    = PCIn;
        MemRead    = 1'b0;
        ARF_RegSel = 3'b000;
        ARF_FunSel = 2'b00;

        case (state)
            S_IDLE, S_ERROR: begin
                if (Start) begin
                    state_d = S_READ_LO;
                    cnt_d   = '0;
                end
            end
            S_READ_LO, S_READ_HI: begin
                mem_rd = 1'b1;
                if (MemReady) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    if (state == S_READ_LO) begin
                        lo_byte_d = MemData;
                        state_d   = S_READ_HI;
                    end else begin
                        ir_d    = {MemData, lo_byte};
                        state_d = S_DONE;
                    end
                end else begin
                    if (cnt != CNT_MAX) begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                    if (TO_EN && (cnt == CNT_LAST)) begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reset blanks the strobes so the PC cannot move while the block is held.
        MemRead = mem_rd & ~Reset;
        if (capture && !Reset) begin
            ARF_RegSel = 3'b001;
            ARF_FunSel = 2'b01;
        end
    end

    // State, datapath registers and state-decoded status flags.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            lo_byte <= 8'h00;
            IROut   <= 16'h0000;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Error   <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            lo_byte <= lo_byte_d;
            IROut   <= ir_d;
            Busy    <= (state_d == S_READ_LO) || (state_d == S_READ_HI);
            Done    <= (state_d == S_DONE);
            Error   <= (state_d == S_ERROR);
        end
    end

endmodule
